bus_arbiter_n: RTL and testbench

//  N-master bus arbiter with split-transaction support, selectable fixed-priority or

---
 rtl/bus_arbiter_n_if.sv | 46 ++++
 rtl/bus_arbiter_n.sv | 210 +++++++++++++++++++++
 tb/tb_bus_arbiter_n.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_n_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_n_if
// Purpose : groups the request/grant/split handshake between the bus masters,
//           the slaves and the N-master arbiter.
// Modports:
//   master - arbiter side: takes requests and slave status, drives grants,
//            mux select and split status.
//   slave  - requester/slave side (masters, slaves, testbench): drives
//            requests and slave status, observes grants.
// Signals :
//   breq        [NUM_M]  bus request per master
//   sready_nsp           AND of ready from all non-split slaves
//   sready_sp            ready from the split-capable slave
//   ssplit               split response from slave, valid during a grant
//   srelease             1-cycle pulse: split slave can complete the split
//   bgrant      [NUM_M]  one-hot grant, all-zero when idle
//   msel        [MSEL_W] index of the granted master
//   msplit      [NUM_M]  per-master "transaction split" flag
//   split_grant          1-cycle pulse on first cycle of a resumed split grant
//   split_err            sticky: split received while one was outstanding
// ---------------------------------------------------------------------------
interface bus_arbiter_n_if #(
   parameter int NUM_M  = 4,
   parameter int MSEL_W = 2
);
   logic [NUM_M-1:0]  breq;
   logic              sready_nsp;
   logic              sready_sp;
   logic              ssplit;
   logic              srelease;
   logic [NUM_M-1:0]  bgrant;
   logic [MSEL_W-1:0] msel;
   logic [NUM_M-1:0]  msplit;
   logic              split_grant;
   logic              split_err;

   modport master (
      input  breq, sready_nsp, sready_sp, ssplit, srelease,
      output bgrant, msel, msplit, split_grant, split_err
   );

   modport slave (
      output breq, sready_nsp, sready_sp, ssplit, srelease,
      input  bgrant, msel, msplit, split_grant, split_err
   );
endinterface

// File: rtl/bus_arbiter_n.sv
// ---------------------------------------------------------------------------
// bus_arbiter_n
// Purpose : N-master bus arbiter with split-transaction support, fixed-priority
//           or round-robin selection and an optional grant-tenure limit.
//           One split owner can be outstanding; when the split slave releases
//           it, that owner is regranted ahead of every other request.
// Ports   :
//   clk   - clock, rising edge
//   rstn  - synchronous, active-low reset
//   bus   - bus_arbiter_n_if.master (requests, slave status, grants, split
//           flags; see the interface file for the signal list)
// All outputs are registered: a decision taken in IDLE at one edge shows on
// bgrant/msel after that edge. There is always at least one IDLE cycle
// between two grants.
// ---------------------------------------------------------------------------
module bus_arbiter_n #(
   parameter int NUM_M    = 4,
   parameter int MSEL_W   = 2,
   parameter int RR_MODE  = 1,
   parameter int MAX_HOLD = 0
) (
   input  logic               clk,
   input  logic               rstn,
   bus_arbiter_n_if.master    bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int HOLD_W = 16;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

   state_t            state_q, state_d;
   logic [NUM_M-1:0]  bgrant_q, bgrant_d;
   logic [MSEL_W-1:0] msel_q, msel_d;
   logic [NUM_M-1:0]  msplit_q, msplit_d;
   logic              split_grant_q, split_grant_d;
   logic              split_err_q, split_err_d;
   logic              split_valid_q, split_valid_d;
   logic [MSEL_W-1:0] split_owner_q, split_owner_d;
   logic              rel_pend_q, rel_pend_d;
   logic [MSEL_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

   logic [NUM_M-1:0]  eligible;
   logic              win_found;
   logic [MSEL_W-1:0] win_idx;
   logic [NUM_M-1:0]  win_oh;
   logic [NUM_M-1:0]  split_owner_oh;
   logic              ready_ok;
   logic              owner_req;
   logic              other_eligible;
   logic              tenure_expired;

   // Pointer to the master after idx, wrapping at NUM_M (not at 2**MSEL_W).
   function automatic logic [MSEL_W-1:0] ptr_after(input logic [MSEL_W-1:0] idx);
      return MSEL_W'((int'(idx) + 1) % NUM_M);
   endfunction

   // A master whose transaction is split may not compete until it is resumed.
   assign eligible = bus.breq & ~msplit_q;

   // The split slave's ready only matters while it has no split parked on it.
   assign ready_ok = bus.sready_nsp & (split_valid_q | bus.sready_sp);

   // Round-robin search in two passes: first eligible index at or above the
   // pointer, otherwise the lowest eligible index (the wrap). With a zero base
   // both passes agree, which gives plain fixed priority.
   always_comb begin
      logic [MSEL_W-1:0] base;
      logic              found_hi;
      logic              found_lo;
      int                hi_idx;
      int                lo_idx;
      base     = (RR_MODE != 0) ? rr_ptr_q : '0;
      found_hi = 1'b0;
      found_lo = 1'b0;
      hi_idx   = 0;
      lo_idx   = 0;
      for (int b = 0; b < NUM_M; b++) begin
         if (eligible[b] && !found_lo) begin
            found_lo = 1'b1;
            lo_idx   = b;
         end
         if (eligible[b] && !found_hi && (b >= int'(base))) begin
            found_hi = 1'b1;
            hi_idx   = b;
         end
      end
      win_found = found_lo;
      win_idx   = found_hi ? MSEL_W'(hi_idx) : MSEL_W'(lo_idx);
   end

   generate
      for (genvar gi = 0; gi < NUM_M; gi++) begin : g_onehot
         assign win_oh[gi]         = (win_idx == MSEL_W'(gi));
         assign split_owner_oh[gi] = (split_owner_q == MSEL_W'(gi));
      end
   endgenerate

   assign owner_req      = |(bus.breq & bgrant_q);
   assign other_eligible = |(eligible & ~bgrant_q);
   // Tenure only forces a handover when someone else is actually waiting.
   assign tenure_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && other_eligible;

   always_comb begin
      state_d       = state_q;
      bgrant_d      = bgrant_q;
      msel_d        = msel_q;
      msplit_d      = msplit_q;
      split_grant_d = 1'b0;
      split_err_d   = split_err_q;
      split_valid_d = split_valid_q;
      split_owner_d = split_owner_q;
      rel_pend_d    = rel_pend_q;
      rr_ptr_d      = rr_ptr_q;
      hold_cnt_d    = hold_cnt_q;

      // A release only counts against a split that is already registered;
      // one arriving with the split response itself is dropped.
      if (bus.srelease && split_valid_q) begin
         rel_pend_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (split_valid_q && rel_pend_q) begin
               // Resume the split owner, even if it has stopped requesting.
               state_d       = GRANT;
               bgrant_d      = split_owner_oh;
               msel_d        = split_owner_q;
               split_grant_d = 1'b1;
               msplit_d      = msplit_q & ~split_owner_oh;
               split_valid_d = 1'b0;
               rel_pend_d    = 1'b0;
               rr_ptr_d      = ptr_after(split_owner_q);
               hold_cnt_d    = '0;
            end else if (win_found && ready_ok) begin
               state_d    = GRANT;
               bgrant_d   = win_oh;
               msel_d     = win_idx;
               rr_ptr_d   = ptr_after(win_idx);
               hold_cnt_d = '0;
            end
         end

         GRANT: begin
            if (hold_cnt_q != HOLD_SAT) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
            if (bus.ssplit) begin
               if (!split_valid_q) begin
                  msplit_d      = msplit_q | bgrant_q;
                  split_owner_d = msel_q;
                  split_valid_d = 1'b1;
               end else begin
                  split_err_d = 1'b1;
               end
            end
            if (!owner_req || bus.ssplit || tenure_expired) begin
               state_d  = IDLE;
               bgrant_d = '0;
            end
         end

         default: begin
            state_d  = IDLE;
            bgrant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= IDLE;
         bgrant_q      <= '0;
         msel_q        <= '0;
         msplit_q      <= '0;
         split_grant_q <= 1'b0;
         split_err_q   <= 1'b0;
         split_valid_q <= 1'b0;
         split_owner_q <= '0;
         rel_pend_q    <= 1'b0;
         rr_ptr_q      <= '0;
         hold_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         bgrant_q      <= bgrant_d;
         msel_q        <= msel_d;
         msplit_q      <= msplit_d;
         split_grant_q <= split_grant_d;
         split_err_q   <= split_err_d;
         split_valid_q <= split_valid_d;
         split_owner_q <= split_owner_d;
         rel_pend_q    <= rel_pend_d;
         rr_ptr_q      <= rr_ptr_d;
         hold_cnt_q    <= hold_cnt_d;
      end
   end

   assign bus.bgrant      = bgrant_q;
   assign bus.msel        = msel_q;
   assign bus.msplit      = msplit_q;
   assign bus.split_grant = split_grant_q;
   assign bus.split_err   = split_err_q;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_n
// Two arbiters share clock and reset: a fixed-priority one with unlimited
// tenure (driven from a vector table, including the split sequences) and a
// round-robin one with a two-cycle tenure limit (hand-written sequences).
// ---------------------------------------------------------------------------
module tb_bus_arbiter_n;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   bus_arbiter_n_if #(.NUM_M(4), .MSEL_W(2)) if_fp ();
   bus_arbiter_n_if #(.NUM_M(4), .MSEL_W(2)) if_rr ();

   bus_arbiter_n #(.NUM_M(4), .MSEL_W(2), .RR_MODE(0), .MAX_HOLD(0)) dut_fp (
      .clk  (clk),
      .rstn (rstn),
      .bus  (if_fp)
   );

   bus_arbiter_n #(.NUM_M(4), .MSEL_W(2), .RR_MODE(1), .MAX_HOLD(2)) dut_rr (
      .clk  (clk),
      .rstn (rstn),
      .bus  (if_rr)
   );

   typedef struct {
      logic [3:0] breq;
      logic       ssplit;
      logic       srel;
      logic       sp_rdy;
      logic       nsp_rdy;
      logic [3:0] e_bg;
      logic [1:0] e_msel;
      logic [3:0] e_msplit;
      logic       e_sg;
      logic       e_serr;
   } vec_t;

   localparam int NVEC = 26;
   vec_t vecs [NVEC];

   function automatic vec_t mk(logic [3:0] breq, logic ssplit, logic srel, logic sp_rdy,
                               logic nsp_rdy, logic [3:0] e_bg, logic [1:0] e_msel,
                               logic [3:0] e_msplit, logic e_sg, logic e_serr);
      vec_t v;
      v.breq = breq;   v.ssplit = ssplit; v.srel = srel;   v.sp_rdy = sp_rdy;
      v.nsp_rdy = nsp_rdy; v.e_bg = e_bg; v.e_msel = e_msel; v.e_msplit = e_msplit;
      v.e_sg = e_sg;   v.e_serr = e_serr;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%0h exp=%0h", name, idx, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int         exp_rr [14];
   logic [1:0] last_msel;

   initial begin
      // breq, ssplit, srel, sp, nsp | bgrant, msel, msplit, split_grant, split_err
      vecs[0]  = mk(4'b1010, 0, 0, 1, 1, 4'b0010, 2'd1, 4'b0000, 0, 0); // fixed prio picks M1
      vecs[1]  = mk(4'b1010, 0, 0, 1, 1, 4'b0010, 2'd1, 4'b0000, 0, 0);
      vecs[2]  = mk(4'b1000, 0, 0, 1, 1, 4'b0000, 2'd1, 4'b0000, 0, 0); // M1 drops -> idle
      vecs[3]  = mk(4'b1000, 0, 0, 1, 1, 4'b1000, 2'd3, 4'b0000, 0, 0); // then M3
      vecs[4]  = mk(4'b0000, 0, 0, 1, 1, 4'b0000, 2'd3, 4'b0000, 0, 0);
      vecs[5]  = mk(4'b0001, 0, 0, 1, 0, 4'b0000, 2'd3, 4'b0000, 0, 0); // nsp not ready
      vecs[6]  = mk(4'b0001, 0, 0, 0, 1, 4'b0000, 2'd3, 4'b0000, 0, 0); // sp not ready, no split
      vecs[7]  = mk(4'b0000, 0, 1, 1, 1, 4'b0000, 2'd3, 4'b0000, 0, 0); // stray release
      vecs[8]  = mk(4'b0100, 0, 0, 1, 1, 4'b0100, 2'd2, 4'b0000, 0, 0); // M2 granted
      vecs[9]  = mk(4'b0100, 1, 1, 1, 1, 4'b0000, 2'd2, 4'b0100, 0, 0); // split + same-cycle release
      vecs[10] = mk(4'b0100, 0, 0, 1, 1, 4'b0000, 2'd2, 4'b0100, 0, 0); // M2 masked, no resume
      vecs[11] = mk(4'b0101, 0, 0, 0, 1, 4'b0001, 2'd0, 4'b0100, 0, 0); // M0 with sp not ready
      vecs[12] = mk(4'b0101, 0, 1, 0, 1, 4'b0001, 2'd0, 4'b0100, 0, 0); // release pulse
      vecs[13] = mk(4'b0100, 0, 0, 1, 1, 4'b0000, 2'd0, 4'b0100, 0, 0); // M0 drops
      vecs[14] = mk(4'b0100, 0, 0, 1, 1, 4'b0100, 2'd2, 4'b0000, 1, 0); // M2 resumed
      vecs[15] = mk(4'b0100, 0, 0, 1, 1, 4'b0100, 2'd2, 4'b0000, 0, 0); // pulse ends
      vecs[16] = mk(4'b0000, 0, 0, 1, 1, 4'b0000, 2'd2, 4'b0000, 0, 0);
      vecs[17] = mk(4'b0010, 0, 0, 1, 1, 4'b0010, 2'd1, 4'b0000, 0, 0); // M1 granted
      vecs[18] = mk(4'b0010, 1, 0, 1, 1, 4'b0000, 2'd1, 4'b0010, 0, 0); // split on M1
      vecs[19] = mk(4'b1000, 0, 0, 1, 1, 4'b1000, 2'd3, 4'b0010, 0, 0); // M3 granted
      vecs[20] = mk(4'b1000, 1, 0, 1, 1, 4'b0000, 2'd3, 4'b0010, 0, 1); // second split -> err
      vecs[21] = mk(4'b0000, 0, 0, 1, 1, 4'b0000, 2'd3, 4'b0010, 0, 1);
      vecs[22] = mk(4'b0000, 0, 1, 1, 1, 4'b0000, 2'd3, 4'b0010, 0, 1); // release M1
      vecs[23] = mk(4'b0000, 0, 0, 1, 1, 4'b0010, 2'd1, 4'b0000, 1, 1); // resume with breq low
      vecs[24] = mk(4'b0000, 0, 0, 1, 1, 4'b0000, 2'd1, 4'b0000, 0, 1); // owner not requesting
      vecs[25] = mk(4'b0000, 0, 0, 1, 1, 4'b0000, 2'd1, 4'b0000, 0, 1);

      exp_rr = '{0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0, 0};

      // Reset with every master requesting.
      if_fp.breq = 4'hF; if_fp.ssplit = 0; if_fp.srelease = 0;
      if_fp.sready_sp = 1; if_fp.sready_nsp = 1;
      if_rr.breq = 4'hF; if_rr.ssplit = 0; if_rr.srelease = 0;
      if_rr.sready_sp = 1; if_rr.sready_nsp = 1;
      rstn = 1'b0;
      tick();
      tick();
      chk("rst_fp_bgrant", 0, 8'(if_fp.bgrant), 8'h0);
      chk("rst_fp_msel",   0, 8'(if_fp.msel),   8'h0);
      chk("rst_fp_msplit", 0, 8'(if_fp.msplit), 8'h0);
      chk("rst_fp_serr",   0, 8'(if_fp.split_err),   8'h0);
      chk("rst_fp_sgrant", 0, 8'(if_fp.split_grant), 8'h0);
      chk("rst_rr_bgrant", 0, 8'(if_rr.bgrant), 8'h0);
      chk("rst_rr_msel",   0, 8'(if_rr.msel),   8'h0);
      chk("rst_rr_msplit", 0, 8'(if_rr.msplit), 8'h0);
      chk("rst_rr_serr",   0, 8'(if_rr.split_err),   8'h0);
      $display("reset bgrant_fp=%b bgrant_rr=%b", if_fp.bgrant, if_rr.bgrant);
      if_fp.breq = 4'h0;
      if_rr.breq = 4'h0;
      rstn = 1'b1;
      tick();

      // Fixed-priority / split vectors.
      for (int i = 0; i < NVEC; i++) begin
         if_fp.breq       = vecs[i].breq;
         if_fp.ssplit     = vecs[i].ssplit;
         if_fp.srelease   = vecs[i].srel;
         if_fp.sready_sp  = vecs[i].sp_rdy;
         if_fp.sready_nsp = vecs[i].nsp_rdy;
         tick();
         $display("vec %0d breq=%b ssplit=%b srel=%b -> bgrant=%b msel=%0d msplit=%b sg=%b serr=%b",
                  i, vecs[i].breq, vecs[i].ssplit, vecs[i].srel, if_fp.bgrant, if_fp.msel,
                  if_fp.msplit, if_fp.split_grant, if_fp.split_err);
         chk("fp_bgrant", i, 8'(if_fp.bgrant),      8'(vecs[i].e_bg));
         chk("fp_msel",   i, 8'(if_fp.msel),        8'(vecs[i].e_msel));
         chk("fp_msplit", i, 8'(if_fp.msplit),      8'(vecs[i].e_msplit));
         chk("fp_sgrant", i, 8'(if_fp.split_grant), 8'(vecs[i].e_sg));
         chk("fp_serr",   i, 8'(if_fp.split_err),   8'(vecs[i].e_serr));
      end
      if_fp.breq = 4'h0; if_fp.ssplit = 0; if_fp.srelease = 0;
      if_fp.sready_sp = 1; if_fp.sready_nsp = 1;

      // Round-robin with two-cycle tenure, all masters requesting; covers 3->0 wrap.
      last_msel = 2'd0;
      if_rr.breq = 4'hF;
      for (int i = 0; i < 14; i++) begin
         logic [3:0] eb;
         tick();
         eb = 4'h0;
         if (exp_rr[i] >= 0) begin
            eb = 4'(1 << exp_rr[i]);
            last_msel = 2'(exp_rr[i]);
         end
         $display("rr %0d bgrant=%b msel=%0d", i, if_rr.bgrant, if_rr.msel);
         chk("rr_bgrant", i, 8'(if_rr.bgrant), 8'(eb));
         chk("rr_msel",   i, 8'(if_rr.msel),   8'(last_msel));
      end

      // M0 stops requesting; M2 is next after the pointer and, alone, is never preempted.
      if_rr.breq = 4'b0100;
      tick();
      $display("rr_drop bgrant=%b msel=%0d", if_rr.bgrant, if_rr.msel);
      chk("rr_drop_bgrant", 0, 8'(if_rr.bgrant), 8'h0);
      chk("rr_drop_msel",   0, 8'(if_rr.msel),   8'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         $display("rr_alone %0d bgrant=%b msel=%0d", i, if_rr.bgrant, if_rr.msel);
         chk("rr_alone_bgrant", i, 8'(if_rr.bgrant), 8'h4);
         chk("rr_alone_msel",   i, 8'(if_rr.msel),   8'h2);
      end

      // Reset in the middle of a grant.
      rstn = 1'b0;
      tick();
      $display("midrst bgrant=%b msel=%0d", if_rr.bgrant, if_rr.msel);
      chk("midrst_bgrant", 0, 8'(if_rr.bgrant), 8'h0);
      chk("midrst_msel",   0, 8'(if_rr.msel),   8'h0);
      rstn = 1'b1;
      if_rr.breq = 4'h0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
